// File: rtl/slurm16_cpu_writeback_if.sv
// Signal bundle between the SLURM16 pipeline and its register-file write stage:
// slot 2 instruction and results, load return, read selects, forwarding and write port.
interface slurm16_cpu_writeback_if #(
  parameter int BITS          = 16,
  parameter int REGISTER_BITS = 7
);
  logic [BITS-1:0]          instruction;
  logic                     ins_valid;
  logic                     cond_pass;
  logic [BITS-1:0]          alu_result;
  logic [BITS-1:0]          pc_link;
  logic                     mem_rvalid;
  logic [BITS-1:0]          mem_rdata;
  logic [REGISTER_BITS-1:0] regA_sel;
  logic [REGISTER_BITS-1:0] regB_sel;
  logic                     stall;
  logic                     hazard_a;
  logic                     hazard_b;
  logic                     fwd_a_valid;
  logic [BITS-1:0]          fwd_a_data;
  logic                     fwd_b_valid;
  logic [BITS-1:0]          fwd_b_data;
  logic                     wr_en;
  logic [REGISTER_BITS-1:0] wr_sel;
  logic [BITS-1:0]          wr_data;

  modport master (
    output instruction, ins_valid, cond_pass, alu_result, pc_link,
           mem_rvalid, mem_rdata, regA_sel, regB_sel,
    input  stall, hazard_a, hazard_b, fwd_a_valid, fwd_a_data,
           fwd_b_valid, fwd_b_data, wr_en, wr_sel, wr_data
  );

  modport slave (
    input  instruction, ins_valid, cond_pass, alu_result, pc_link,
           mem_rvalid, mem_rdata, regA_sel, regB_sel,
    output stall, hazard_a, hazard_b, fwd_a_valid, fwd_a_data,
           fwd_b_valid, fwd_b_data, wr_en, wr_sel, wr_data
  );
endinterface

// File: rtl/slurm16_cpu_writeback.sv
// SLURM16 register-file write side: decodes the slot 2 destination, carries it through
// memory and writeback, drives the write port, stalls on loads and resolves read hazards.
module slurm16_cpu_writeback #(
  parameter int                       BITS          = 16,
  parameter int                       REGISTER_BITS = 7,
  parameter logic [REGISTER_BITS-1:0] LINK_REGISTER = 7'd15
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  slurm16_cpu_writeback_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ALU_RR = 4'h2,
    OP_ALU_RI = 4'h3,
    OP_BRANCH = 4'h4,
    OP_CMOV   = 4'h5,
    OP_MEM_A  = 4'hA,
    OP_MEM_B  = 4'hB
  } opcode_e;

  typedef logic [REGISTER_BITS-1:0] sel_t;
  typedef logic [BITS-1:0]          word_t;

  typedef struct packed {
    logic  v;
    logic  load;
    sel_t  dest;
    word_t data;
  } slot_t;

  typedef struct packed {
    logic  valid;
    logic  hazard;
    word_t data;
  } fwd_t;

  slot_t      s2;
  slot_t      s3;
  logic       writes2;
  logic [3:0] opcode;
  logic       stall;
  logic       wr_en;
  sel_t       wr_sel;
  word_t      wr_data;
  sel_t       rd_sel [2];
  fwd_t       fwd    [2];
  logic       unused_ins_bits;

  assign opcode          = bus.instruction[15:12];
  assign unused_ins_bits = ^{bus.instruction[10:8], bus.instruction[3:0]};

  // Slot 2 write decode; a load carries no data yet, memory supplies it later.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skipped an assignment would infer a latch.
    writes2 = 1'b0;
    s2      = '0;
    s2.dest = sel_t'(bus.instruction[7:4]);
    s2.data = bus.alu_result;
    case (opcode)
      OP_ALU_RR, OP_ALU_RI: writes2 = 1'b1;
      OP_BRANCH: begin
        if (bus.instruction[11]) begin
          writes2 = 1'b1;
          s2.dest = LINK_REGISTER;
          s2.data = bus.pc_link;
        end
      end
      OP_CMOV: writes2 = bus.cond_pass;
      OP_MEM_A, OP_MEM_B: begin
        if (!bus.instruction[12]) begin
          writes2 = 1'b1;
          s2.load = 1'b1;
          s2.data = '0;
        end
      end
      default: writes2 = 1'b0;
    endcase
    s2.v = bus.ins_valid & writes2 & (s2.dest != '0);
  end

  assign stall = s3.v & s3.load & ~bus.mem_rvalid;

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so each register samples pre-edge values whatever the statement order.
    if (!RSTb) begin
      s3      <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      if (!stall) s3 <= s2;
      // A waiting load turns the write port into a bubble until its data returns.
      wr_en   <= s3.v & ~stall;
      wr_sel  <= s3.dest;
      wr_data <= s3.load ? bus.mem_rdata : s3.data;
    end
  end

  assign rd_sel[0] = bus.regA_sel;
  assign rd_sel[1] = bus.regB_sel;

  // Newest producer wins: slot 2, then slot 3, then the write currently on the port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd[p] = '0;
      if (rd_sel[p] != '0) begin
        if (s2.v && s2.dest == rd_sel[p]) begin
          fwd[p].hazard = s2.load;
          fwd[p].valid  = ~s2.load;
          fwd[p].data   = s2.data;
        end else if (s3.v && s3.dest == rd_sel[p]) begin
          if (!s3.load) begin
            fwd[p].valid = 1'b1;
            fwd[p].data  = s3.data;
          end else if (bus.mem_rvalid) begin
            fwd[p].valid = 1'b1;
            fwd[p].data  = bus.mem_rdata;
          end else begin
            fwd[p].hazard = 1'b1;
          end
        end else if (wr_en && wr_sel == rd_sel[p]) begin
          fwd[p].valid = 1'b1;
          fwd[p].data  = wr_data;
        end
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.hazard_a    = fwd[0].hazard;
  assign bus.fwd_a_valid = fwd[0].valid;
  assign bus.fwd_a_data  = fwd[0].data;
  assign bus.hazard_b    = fwd[1].hazard;
  assign bus.fwd_b_valid = fwd[1].valid;
  assign bus.fwd_b_data  = fwd[1].data;
  assign bus.wr_en       = wr_en;
  assign bus.wr_sel      = wr_sel;
  assign bus.wr_data     = wr_data;

endmodule

// File: tb/tb_slurm16_cpu_writeback.sv
// Bench for slurm16_cpu_writeback: directed scenarios, then random traffic checked
// against a model that tracks in-flight register writes as a queue.
module tb_slurm16_cpu_writeback;

  logic CLK = 1'b0;
  logic RSTb;
  always #5 CLK = ~CLK;

  slurm16_cpu_writeback_if #(.BITS(16), .REGISTER_BITS(7)) bus ();

  slurm16_cpu_writeback dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: writes decoded but not yet written back, plus the write on the port.
  typedef struct {
    bit load;
    int dest;
    int data;
  } wr_rec_t;

  wr_rec_t pending[$];
  bit      m_wr_en;
  int      m_wr_sel;
  int      m_wr_data;
  bit      m_stall;
  bit      model_ok = 1'b0;
  bit      cur_w;
  wr_rec_t cur_r;

  function automatic bit decode(input logic [15:0] ins, input bit valid, input bit cp,
                                input logic [15:0] alu, input logic [15:0] pc,
                                output wr_rec_t r);
    int op;
    bit w;
    op     = int'(ins[15:12]);
    r.load = 1'b0;
    r.dest = int'(ins[7:4]);
    r.data = int'(alu);
    w      = 1'b0;
    if (op == 2 || op == 3) w = 1'b1;
    else if (op == 4 && ins[11]) begin
      w = 1'b1;
      r.dest = 15;
      r.data = int'(pc);
    end else if (op == 5) w = cp;
    else if ((op == 10 || op == 11) && !ins[12]) begin
      w = 1'b1;
      r.load = 1'b1;
      r.data = 0;
    end
    if (!valid || r.dest == 0) w = 1'b0;
    return w;
  endfunction

  function automatic void expect_fwd(input int sel, input bit w2, input wr_rec_t r2,
                                     output bit v, output bit hz, output int d);
    v = 1'b0; hz = 1'b0; d = 0;
    if (sel == 0) return;
    if (w2 && r2.dest == sel) begin
      if (r2.load) hz = 1'b1;
      else begin v = 1'b1; d = r2.data; end
      return;
    end
    if (pending.size() > 0 && pending[0].dest == sel) begin
      if (!pending[0].load) begin v = 1'b1; d = pending[0].data; end
      else if (bus.mem_rvalid) begin v = 1'b1; d = int'(bus.mem_rdata); end
      else hz = 1'b1;
      return;
    end
    if (m_wr_en && m_wr_sel == sel) begin v = 1'b1; d = m_wr_data; end
  endfunction

  task automatic drive(input logic [15:0] ins, input bit valid, input bit cp,
                       input logic [15:0] alu, input logic [15:0] pc,
                       input bit mv, input logic [15:0] md,
                       input logic [6:0] a, input logic [6:0] b);
    bus.instruction = ins;
    bus.ins_valid   = valid;
    bus.cond_pass   = cp;
    bus.alu_result  = alu;
    bus.pc_link     = pc;
    bus.mem_rvalid  = mv;
    bus.mem_rdata   = md;
    bus.regA_sel    = a;
    bus.regB_sel    = b;
  endtask

  // Combinational checks, mid-cycle.
  task automatic eval();
    bit v;
    bit hz;
    int d;
    #1;
    cur_w   = decode(bus.instruction, bus.ins_valid, bus.cond_pass, bus.alu_result, bus.pc_link, cur_r);
    m_stall = pending.size() > 0 && pending[0].load && !bus.mem_rvalid;
    if (!model_ok) return;
    check("stall", bus.stall, m_stall);
    expect_fwd(int'(bus.regA_sel), cur_w, cur_r, v, hz, d);
    check("hazard_a", bus.hazard_a, hz);
    check("fwd_a_valid", bus.fwd_a_valid, v);
    if (v) check("fwd_a_data", bus.fwd_a_data, d);
    expect_fwd(int'(bus.regB_sel), cur_w, cur_r, v, hz, d);
    check("hazard_b", bus.hazard_b, hz);
    check("fwd_b_valid", bus.fwd_b_valid, v);
    if (v) check("fwd_b_data", bus.fwd_b_data, d);
  endtask

  // Clock edge, model update and write-port checks just after it.
  task automatic tick();
    wr_rec_t head;
    bit      rst;
    int      md;
    rst = !RSTb;
    md  = int'(bus.mem_rdata);
    @(posedge CLK);
    #1;
    if (rst) begin
      pending.delete();
      m_wr_en   = 1'b0;
      m_wr_sel  = 0;
      m_wr_data = 0;
      model_ok  = 1'b1;
    end else begin
      m_wr_en = 1'b0;
      if (!m_stall) begin
        if (pending.size() > 0) begin
          head      = pending.pop_front();
          m_wr_en   = 1'b1;
          m_wr_sel  = head.dest;
          m_wr_data = head.load ? md : head.data;
        end
        if (cur_w) pending.push_back(cur_r);
      end
    end
    if (model_ok) begin
      check("wr_en", bus.wr_en, m_wr_en);
      if (m_wr_en) begin
        check("wr_sel", bus.wr_sel, m_wr_sel);
        check("wr_data", bus.wr_data, m_wr_data);
      end
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [15:0] ins;
    bit          hold;

    RSTb = 1'b0;
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_sel", bus.wr_sel, 0);
    check("rst_wr_data", bus.wr_data, 0);
    RSTb = 1'b1;
    eval();
    check("rst_stall", bus.stall, 0);
    check("rst_fwd_a_valid", bus.fwd_a_valid, 0);

    // ALU reg-reg to r5
    drive(16'h2350, 1, 0, 16'h1234, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("alu_wr_en_early", bus.wr_en, 0);
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("alu_wr_en", bus.wr_en, 1);
    check("alu_wr_sel", bus.wr_sel, 5);
    check("alu_wr_data", bus.wr_data, 16'h1234);
    eval(); tick();
    check("alu_wr_en_after", bus.wr_en, 0);

    // Load to r7 with three wait cycles
    drive(16'hA070, 1, 0, 16'h5555, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    for (int i = 0; i < 3; i++) begin
      eval();
      check("load_stall_wait", bus.stall, 1);
      tick();
      check("load_bubble", bus.wr_en, 0);
    end
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 1, 16'hBEEF, 7'd0, 7'd0);
    eval();
    check("load_stall_release", bus.stall, 0);
    tick();
    check("load_wr_en", bus.wr_en, 1);
    check("load_wr_sel", bus.wr_sel, 7);
    check("load_wr_data", bus.wr_data, 16'hBEEF);
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("load_no_dup", bus.wr_en, 0);

    // Load-use hazard on A, resolved by returning data
    drive(16'hA070, 1, 0, 16'h0, 16'h0, 0, 16'h0, 7'd7, 7'd0);
    eval();
    check("haz_a_set", bus.hazard_a, 1);
    check("haz_fwd_a_off", bus.fwd_a_valid, 0);
    tick();
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 1, 16'h0042, 7'd7, 7'd0);
    eval();
    check("haz_a_clear", bus.hazard_a, 0);
    check("haz_fwd_a_valid", bus.fwd_a_valid, 1);
    check("haz_fwd_a_data", bus.fwd_a_data, 16'h0042);
    tick();

    // Back-to-back writes to r3
    drive(16'h2330, 1, 0, 16'h1111, 16'h0, 0, 16'h0, 7'd0, 7'd3);
    eval();
    check("b2b_fwd_first", bus.fwd_b_data, 16'h1111);
    tick();
    drive(16'h2330, 1, 0, 16'h2222, 16'h0, 0, 16'h0, 7'd0, 7'd3);
    eval();
    check("b2b_fwd_newest", bus.fwd_b_data, 16'h2222);
    tick();
    check("b2b_wr_first", bus.wr_data, 16'h1111);
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd3);
    eval();
    check("b2b_fwd_slot3", bus.fwd_b_data, 16'h2222);
    tick();
    check("b2b_wr_second", bus.wr_data, 16'h2222);
    eval(); tick();

    // Link, failed cmov, write to r0
    drive(16'h4800, 1, 0, 16'h0, 16'h0100, 0, 16'h0, 7'd0, 7'd0);
    eval();
    check("r0_no_fwd_link", bus.fwd_a_valid, 0);
    tick();
    drive(16'h5230, 1, 0, 16'h9999, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("link_wr_en", bus.wr_en, 1);
    check("link_wr_sel", bus.wr_sel, 15);
    check("link_wr_data", bus.wr_data, 16'h0100);
    drive(16'h2300, 1, 0, 16'h7777, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval();
    check("r0_no_fwd_alu", bus.fwd_a_valid, 0);
    tick();
    check("cmov_fail_no_wr", bus.wr_en, 0);
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("r0_no_wr", bus.wr_en, 0);

    // Reset during a load wait
    drive(16'hA070, 1, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval();
    check("rstload_stall", bus.stall, 1);
    RSTb = 1'b0;
    tick();
    check("rstload_wr_en", bus.wr_en, 0);
    RSTb = 1'b1;
    eval();
    check("rstload_stall_gone", bus.stall, 0);
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 1, 16'h1234, 7'd7, 7'd0);
    eval(); tick();
    check("stray_rvalid_no_wr", bus.wr_en, 0);
    drive(16'h0000, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'd0, 7'd0);
    eval(); tick();
    check("stray_rvalid_no_wr2", bus.wr_en, 0);

    // Random traffic; slot 2 is held stable while the pipe stalls
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        rnd = $urandom();
        ins = rnd[15:0];
        case ($urandom_range(0, 7))
          0: ins[15:12] = 4'h2;
          1: ins[15:12] = 4'h3;
          2: ins[15:12] = 4'h4;
          3: ins[15:12] = 4'h5;
          4: ins[15:12] = 4'hA;
          5: ins[15:12] = 4'hB;
          default: ;
        endcase
        bus.instruction = ins;
        bus.ins_valid   = ($urandom_range(0, 3) != 0);
        bus.cond_pass   = rnd[16];
        bus.alu_result  = 16'($urandom());
        bus.pc_link     = 16'($urandom());
      end
      bus.mem_rvalid = ($urandom_range(0, 9) < 4);
      bus.mem_rdata  = 16'($urandom());
      bus.regA_sel   = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      bus.regB_sel   = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      RSTb           = ($urandom_range(0, 99) != 0);
      eval();
      hold = m_stall && RSTb;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
